// File: rtl/timer_ctrl_pkg.sv
// Shared types and widths for the timer controller and its helpers.
package timer_ctrl_pkg;

    localparam int TIMER_W = 10;
    localparam int CNT_W   = 8;
    localparam int WD_W    = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        RUN    = 2'd2,
        EXPIRE = 2'd3
    } state_t;

endpackage

// File: rtl/timer_10bit.sv
// Simple 10-bit up-counting timer: cleared by resetn low, counts while
// active, and holds done high once the count equals final_value.
module timer_10bit
    import timer_ctrl_pkg::*;
(
    input  logic               clock,
    input  logic               resetn,
    input  logic               active,
    input  logic [TIMER_W-1:0] final_value,
    output logic               done
);

    logic [TIMER_W-1:0] cnt;

    // Count up while enabled, stopping at the final value.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (active && !done) begin
            cnt <= cnt + TIMER_W'(1);
        end
    end

    assign done = resetn && (cnt == final_value);

endmodule

// File: rtl/timer_watchdog.sv
// Counts RUN cycles and flags a timeout once the count reaches
// final_value + SLACK without the timer completing.
module timer_watchdog
    import timer_ctrl_pkg::*;
#(
    parameter int SLACK = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic [TIMER_W-1:0] final_value,
    output logic               timeout
);

    logic [WD_W-1:0] cnt;
    logic [WD_W-1:0] limit;

    // Sum is computed in 11 bits so the largest final value plus slack cannot wrap.
    assign limit = WD_W'(final_value) + WD_W'(SLACK);

    // Counter is held at zero outside RUN, so every RUN entry starts a fresh count.
    always_ff @(posedge clock) begin
        if (reset || !run) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WD_W'(1);
        end
    end

    // Fires in the RUN cycle that completes the limit-th RUN cycle.
    assign timeout = run && ((cnt + WD_W'(1)) == limit);

endmodule

// File: rtl/timer_ctrl_master.sv
// Request-side controller for timer_10bit: sequences clear/run, converts the
// timer's done level into a one-cycle expired pulse, supports one-shot and
// periodic requests. Optional RUN watchdog built when TIMER_CTRL_WATCHDOG_EN
// is defined; otherwise fault is tied low and RUN waits indefinitely.
//
// state  | meaning
// IDLE   | waiting for a request, timer held clear
// CLEAR  | one-cycle timer clear before counting
// RUN    | timer counting, waiting for done
// EXPIRE | one-cycle expired pulse, then repeat or return to IDLE
module timer_ctrl_master
    import timer_ctrl_pkg::*;
#(
    parameter int WATCHDOG_SLACK = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    input  logic [TIMER_W-1:0] req_value,
    input  logic               req_repeat,
    output logic               req_ready,
    input  logic               cancel,
    output logic               expired,
    output logic               busy,
    output logic [CNT_W-1:0]   expire_count,
    output logic               fault,
    output logic               resetn_timer,
    output logic               timer_active,
    output logic [TIMER_W-1:0] timer_final_value,
    input  logic               timer_done
);

    state_t state;
    state_t state_nxt;
    logic   repeat_q;
    logic   accept;
    logic   wd_timeout;

    assign req_ready = (state == IDLE);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; cancel outranks done, done outranks the watchdog.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                state_nxt = cancel ? IDLE : RUN;
            end
            RUN: begin
                if (cancel) begin
                    state_nxt = IDLE;
                end else if (timer_done) begin
                    state_nxt = EXPIRE;
                end else if (wd_timeout) begin
                    state_nxt = IDLE;
                end
            end
            EXPIRE: begin
                state_nxt = (cancel || !repeat_q) ? IDLE : CLEAR;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs follow the next state so they line up with the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            resetn_timer      <= 1'b0;
            timer_active      <= 1'b0;
            expired           <= 1'b0;
            busy              <= 1'b0;
            expire_count      <= '0;
            timer_final_value <= '0;
            repeat_q          <= 1'b0;
        end else begin
            resetn_timer <= (state_nxt == RUN) || (state_nxt == EXPIRE);
            timer_active <= (state_nxt == RUN);
            expired      <= (state_nxt == EXPIRE);
            busy         <= (state_nxt != IDLE);
            if (accept) begin
                timer_final_value <= req_value;
                repeat_q          <= req_repeat;
                expire_count      <= '0;
            end else if ((state_nxt == EXPIRE) && (expire_count != {CNT_W{1'b1}})) begin
                expire_count <= expire_count + CNT_W'(1);
            end
        end
    end

`ifdef TIMER_CTRL_WATCHDOG_EN
    logic run_state;
    assign run_state = (state == RUN);

    timer_watchdog #(
        .SLACK(WATCHDOG_SLACK)
    ) u_watchdog (
        .clock       (clock),
        .reset       (reset),
        .run         (run_state),
        .final_value (timer_final_value),
        .timeout     (wd_timeout)
    );

    // Fault is sticky until the next accepted request.
    always_ff @(posedge clock) begin
        if (reset) begin
            fault <= 1'b0;
        end else if (accept) begin
            fault <= 1'b0;
        end else if (run_state && !cancel && !timer_done && wd_timeout) begin
            fault <= 1'b1;
        end
    end
`else
    assign wd_timeout = 1'b0;
    assign fault      = 1'b0;
`endif

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Scoreboard bench for timer_ctrl_master driving a real timer_10bit.
// Expected expired pulses (cycle, count) are queued when a request is
// accepted; a negedge monitor pops and compares on every expired pulse.
module tb_timer_ctrl_master;

    logic       clock;
    logic       reset;
    logic       req_valid;
    logic [9:0] req_value;
    logic       req_repeat;
    logic       req_ready;
    logic       cancel;
    logic       expired;
    logic       busy;
    logic [7:0] expire_count;
    logic       fault;
    logic       resetn_timer;
    logic       timer_active;
    logic [9:0] timer_final_value;
    logic       timer_done;
    logic       done_raw;
    logic       force_low;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc;
    int   n_tests;
    int   n_fail;
    int   acc;
    int   acc_b;
    int   waited;

    timer_ctrl_master #(
        .WATCHDOG_SLACK(16)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_value         (req_value),
        .req_repeat        (req_repeat),
        .req_ready         (req_ready),
        .cancel            (cancel),
        .expired           (expired),
        .busy              (busy),
        .expire_count      (expire_count),
        .fault             (fault),
        .resetn_timer      (resetn_timer),
        .timer_active      (timer_active),
        .timer_final_value (timer_final_value),
        .timer_done        (timer_done)
    );

    timer_10bit u_timer (
        .clock       (clock),
        .resetn      (resetn_timer),
        .active      (timer_active),
        .final_value (timer_final_value),
        .done        (done_raw)
    );

    assign timer_done = done_raw & ~force_low;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard monitor: every expired pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset && expired) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_expired: got pulse at cycle %0d count %0d expected none",
                         cyc, expire_count);
            end else begin
                mon_e = sb.pop_front();
                check("expired_cycle", cyc, mon_e.cyc);
                check("expired_count", int'(expire_count), mon_e.cnt);
            end
        end
    end

    task automatic push_expect(input int a, input int value, input int n_pulses);
        exp_t e;
        for (int k = 0; k < n_pulses; k++) begin
            e.cyc = a + 2 + value + k * (3 + value);
            e.cnt = (k + 1 > 255) ? 255 : k + 1;
            sb.push_back(e);
        end
    endtask

    task automatic at_cycle(input int k);
        while (cyc < k) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic sample_at(input int k);
        at_cycle(k);
        @(negedge clock);
    endtask

    // Present a request, wait (bounded) for acceptance, queue its expected pulses.
    task automatic issue(input int value, input bit rpt, input int n_pulses, output int a);
        int w;
        w = 0;
        @(posedge clock);
        #1;
        req_valid  = 1'b1;
        req_value  = 10'(value);
        req_repeat = rpt;
        @(negedge clock);
        while (!req_ready && w < 2000) begin
            @(negedge clock);
            w++;
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_accept_timeout: got req_ready 0 expected 1 after %0d cycles", w);
        end
        @(posedge clock);
        #1;
        a = cyc;
        req_valid = 1'b0;
        push_expect(a, value, n_pulses);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_value  = '0;
        req_repeat = 1'b0;
        cancel     = 1'b0;
        force_low  = 1'b0;

        // Reset held for 5 cycles, then released.
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_resetn_timer", resetn_timer, 0);
        check("rst_timer_active", timer_active, 0);
        check("rst_final_value", timer_final_value, 0);
        check("rst_expired", expired, 0);
        check("rst_busy", busy, 0);
        check("rst_expire_count", expire_count, 0);
        check("rst_fault", fault, 0);
        check("rst_req_ready", req_ready, 1);

        // One-shot, value 12.
        issue(12, 1'b0, 1, acc);
        sample_at(acc);
        check("os_clear_resetn", resetn_timer, 0);
        check("os_clear_busy", busy, 1);
        check("os_clear_ready", req_ready, 0);
        check("os_final_value", timer_final_value, 12);
        sample_at(acc + 1);
        check("os_run_resetn", resetn_timer, 1);
        check("os_run_active", timer_active, 1);
        sample_at(acc + 15);
        check("os_idle_busy", busy, 0);
        check("os_idle_ready", req_ready, 1);
        check("os_idle_count", expire_count, 1);
        check("os_idle_active", timer_active, 0);

        // Periodic, value 5, three periods then cancel during the third pulse.
        issue(5, 1'b1, 3, acc);
        at_cycle(acc + 23);
        cancel = 1'b1;
        @(posedge clock);
        #1;
        cancel = 1'b0;
        @(negedge clock);
        check("per_cancel_busy", busy, 0);
        check("per_cancel_resetn", resetn_timer, 0);
        check("per_cancel_count", expire_count, 3);
        repeat (20) @(negedge clock);
        check("per_no_fourth_count", expire_count, 3);

        // Cancel in the same cycle done is first sampled.
        issue(6, 1'b0, 0, acc);
        at_cycle(acc + 7);
        cancel = 1'b1;
        @(negedge clock);
        check("race_done_seen", timer_done, 1);
        @(posedge clock);
        #1;
        cancel = 1'b0;
        @(negedge clock);
        check("race_busy", busy, 0);
        check("race_expired", expired, 0);
        check("race_count", expire_count, 0);

        // Request while busy is held off; latched value unchanged until IDLE.
        issue(12, 1'b0, 1, acc);
        req_valid  = 1'b1;
        req_value  = 10'd7;
        req_repeat = 1'b0;
        waited     = 0;
        @(negedge clock);
        while (!req_ready && waited < 100) begin
            check("busy_final_value_held", timer_final_value, 12);
            @(negedge clock);
            waited++;
        end
        check("busy_ready_cycle", cyc, acc + 15);
        @(posedge clock);
        #1;
        acc_b     = cyc;
        req_valid = 1'b0;
        push_expect(acc_b, 7, 1);
        @(negedge clock);
        check("busy_accept_cycle", acc_b, acc + 16);
        check("busy_new_final_value", timer_final_value, 7);
        sample_at(acc_b + 10);
        check("busy_second_done", busy, 0);

        // Zero final value is forwarded and completes.
        issue(0, 1'b0, 1, acc);
        sample_at(acc);
        check("zero_final_value", timer_final_value, 0);
        sample_at(acc + 3);
        check("zero_busy", busy, 0);
        check("zero_count", expire_count, 1);

        // Periodic zero-value run long enough to saturate the pulse count.
        issue(0, 1'b1, 258, acc);
        at_cycle(acc + 2 + 257 * 3);
        cancel = 1'b1;
        @(posedge clock);
        #1;
        cancel = 1'b0;
        @(negedge clock);
        check("sat_count", expire_count, 255);
        check("sat_busy", busy, 0);

`ifdef TIMER_CTRL_WATCHDOG_EN
        // Watchdog: done suppressed, value 4 with 16 slack faults after 20 RUN cycles.
        force_low = 1'b1;
        issue(4, 1'b0, 0, acc);
        sample_at(acc + 20);
        check("wd_fault_before", fault, 0);
        check("wd_busy_before", busy, 1);
        sample_at(acc + 21);
        check("wd_fault_set", fault, 1);
        check("wd_busy_after", busy, 0);
        check("wd_expired_after", expired, 0);
        repeat (5) @(negedge clock);
        check("wd_fault_sticky", fault, 1);
        force_low = 1'b0;
        issue(3, 1'b0, 1, acc);
        sample_at(acc);
        check("wd_fault_cleared", fault, 0);
        sample_at(acc + 6);
        check("wd_next_count", expire_count, 1);
`endif

        repeat (10) @(negedge clock);
        check("sb_drained", sb.size(), 0);
        check("final_fault_clear", fault, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_ctrl_master.md
# timer_ctrl_master

Initiator-side controller for the 10-bit timer block: accepts timing requests from application logic, drives the timer's reset/active/final-value inputs, and watches `timer_done`. It turns the timer's level-style completion into a single-cycle `expired` pulse and supports one-shot and periodic modes. It sits between the Bluetooth link/command FSMs and the shared `timer_10bit` instance, so no FSM drives the timer directly.

## Interface
- `WATCHDOG_SLACK`, 16: extra cycles beyond `req_value` before a missing `timer_done` is a fault (only with `TIMER_CTRL_WATCHDOG_EN`).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_value` in 10: timer final value for this request.
- `req_repeat` in 1: 1 = periodic, 0 = one-shot; sampled with the request.
- `req_ready` out 1: high only in IDLE.
- `cancel` in 1: abort the active request.
- `expired` out 1: one-cycle pulse per timer completion.
- `busy` out 1: high in any state except IDLE.
- `expire_count` out 8: saturating count of `expired` pulses since the last accepted request.
- `fault` out 1: watchdog fault, sticky until the next accepted request or reset.
- `resetn_timer` out 1: active-low clear to the timer.
- `timer_active` out 1: timer count enable.
- `timer_final_value` out 10: latched `req_value`.
- `timer_done` in 1: timer completion level.

## Operation
- States are IDLE, CLEAR, RUN and EXPIRE.
- IDLE:
  - `resetn_timer`=0 and `timer_active`=0.
  - On `req_valid & req_ready`: latch `req_value` and `req_repeat`, clear `expire_count` and `fault`, then go to CLEAR.
- CLEAR:
  - `resetn_timer`=0 for exactly one cycle.
  - Go to RUN.
- RUN:
  - `resetn_timer`=1 and `timer_active`=1.
  - When `timer_done` is sampled 1, go to EXPIRE.
- EXPIRE:
  - `expired`=1 for one cycle and `expire_count` increments, saturating at 255.
  - `timer_active`=0.
  - Go to CLEAR if the request is periodic, otherwise go to IDLE.
- `cancel` in CLEAR, RUN or EXPIRE:
  - Go to IDLE next cycle.
  - In EXPIRE the pulse still occurs in that cycle.
  - In RUN, `cancel` beats a simultaneous `timer_done`: no `expired`.
- `cancel` in IDLE has no effect.
- `req_value`=0 is legal and is forwarded unchanged. Completion timing is whatever the timer produces.
- `timer_done` outside RUN is ignored.
- Requests presented while `busy` are not accepted. The requester must hold `req_valid` until `req_ready`.

## Timing
- Reset values:
  - State is IDLE.
  - `resetn_timer`=0, `timer_active`=0, `timer_final_value`=0.
  - `expired`=0, `busy`=0, `expire_count`=0, `fault`=0.
  - `req_ready`=1 from the first cycle after reset deasserts.
- All outputs are registered except `req_ready`, which decodes state.
- Request accepted at edge T:
  - CLEAR during cycle T+1.
  - RUN from T+2, with `timer_active` high starting T+2.
- `timer_done` sampled at edge D in RUN:
  - `expired` high during cycle D+1.
  - Periodic: CLEAR at D+2, RUN at D+3.
  - One-shot: IDLE at D+2, `req_ready` high at D+2.
- `cancel` sampled at edge C: IDLE and `resetn_timer`=0 from C+1.
- `reset` mid-operation returns to reset values at the next edge, regardless of state or `cancel`.

## Configuration
- Macro: `TIMER_CTRL_WATCHDOG_EN`.
- Defined:
  - An 11-bit counter clears on entry to RUN and increments each RUN cycle.
  - If the counter reaches `timer_final_value + WATCHDOG_SLACK` (11-bit sum, no overflow) without `timer_done`, `fault` sets and the FSM goes to IDLE with no `expired`.
  - Periodic requests stop on fault.
- Undefined:
  - No counter is built.
  - `fault` is tied 0.
  - RUN waits indefinitely.

## Structure
- `timer_ctrl_pkg` holds:
  - The state enum (IDLE, CLEAR, RUN, EXPIRE).
  - Width constants TIMER_W=10 and CNT_W=8.
  - The watchdog width WD_W=11.
- One sub-module, `timer_watchdog`, implements the RUN-cycle counter and limit compare. It is instantiated only under `TIMER_CTRL_WATCHDOG_EN`.
- The bench connects the DUT to a real `timer_10bit` instance.

## Test plan
- Reset held 5 cycles, then released: all outputs at reset values, `req_ready`=1.
- One-shot, `req_value`=12: exactly one `expired` pulse, `expire_count`=1, back to IDLE; `resetn_timer` low exactly one cycle after acceptance.
- Periodic, `req_value`=5, run 3 periods, then `cancel`: three `expired` pulses spaced identically, `expire_count`=3, IDLE one cycle after `cancel`, no fourth pulse.
- `cancel` asserted in the same cycle `timer_done` is first sampled: no `expired`, `expire_count` unchanged, `busy`=0 next cycle.
- `req_valid` with `req_value`=7 while busy with a prior request: not accepted until IDLE; the latched `timer_final_value` stays at the prior value until then.
- With `TIMER_CTRL_WATCHDOG_EN`, bench forces `timer_done` low, `req_value`=4, SLACK=16: `fault`=1 after 20 RUN cycles, IDLE, `expired` never pulses; the next accepted request clears `fault`.
